// File: rtl/gpu_pkg.sv
// Shared GPU definitions used by the instruction RAM, the core fetch unit
// and the shader loader.
//
// Contents:
//   GPU_DATA_W     - instruction word width
//   GPU_IMEM_AW    - local instruction RAM address width (1024 words)
//   loader_state_t - shader loader sequencing states
package gpu_pkg;

  localparam int GPU_DATA_W  = 16;
  localparam int GPU_IMEM_AW = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/shader_fetch_pipe.sv
// Read/write datapath of the shader loader.
//
// Issues one external read address per cycle while issue_en is high, follows
// each issue with a valid bit, and one cycle after the external data is
// returned presents it on the instruction RAM write port.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   restart      - rewind the issue counter/address to the first word
//   issue_en     - issue the current address this cycle
//   last_issue   - current address is the final word of the image
//   input_addr   - external program-store read address
//   data_input   - external read data (1-cycle latency)
//   imem_we      - instruction RAM write enable
//   imem_waddr   - instruction RAM write address
//   imem_wdata   - instruction RAM write data
module shader_fetch_pipe
  import gpu_pkg::*;
#(
  parameter int                 ADDR_W     = 20,
  parameter int                 DATA_W     = GPU_DATA_W,
  parameter int                 IMEM_AW    = GPU_IMEM_AW,
  parameter int unsigned        LOAD_WORDS = 288,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               issue_en,
  output logic               last_issue,
  output logic [ADDR_W-1:0]  input_addr,
  input  logic [DATA_W-1:0]  data_input,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [DATA_W-1:0]  imem_wdata
);

  // One extra bit so a full 2**IMEM_AW image can be counted without wrap.
  localparam int CNT_W = IMEM_AW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_WORDS - 1);

  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q;
  logic [IMEM_AW-1:0] idx_q;
  logic               we_q;
  logic [IMEM_AW-1:0] waddr_q;
  logic [DATA_W-1:0]  wdata_q;

  assign last_issue = (issue_cnt_q == LAST_IDX);

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    addr_d      = addr_q;
    if (restart) begin
      issue_cnt_d = '0;
      addr_d      = BASE_ADDR;
    end else if (issue_en && !last_issue) begin
      // After the final issue the address is left on the last word.
      issue_cnt_d = issue_cnt_q + 1'b1;
      addr_d      = BASE_ADDR + ADDR_W'(issue_cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      addr_q      <= BASE_ADDR;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      addr_q      <= addr_d;
      // valid_q/idx_q describe the word whose data is on data_input now.
      valid_q     <= issue_en && !restart;
      idx_q       <= issue_cnt_q[IMEM_AW-1:0];
      we_q        <= valid_q;
      if (valid_q) begin
        waddr_q <= idx_q;
        wdata_q <= data_input;
      end
    end
  end

  assign input_addr = addr_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/shader_loader.sv
// Shader loader: copies a shader image from the external 16-bit program
// store into the GPU's local instruction RAM and holds the core stalled
// until the image is in place.
//
// Optional feature macro: SHADER_LOADER_CHECKSUM_EN adds a running 16-bit
// checksum of written words, compared against expected_sum when the load
// completes; on mismatch the core stays held.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - single-cycle (re)load request, honoured in DONE
//   input_addr    - external program-store read address
//   data_input    - external read data (1-cycle latency)
//   imem_we/imem_waddr/imem_wdata - instruction RAM write port
//   core_hold     - high while the image is not (validly) loaded
//   load_done     - one-cycle pulse at completion
//   words_loaded  - words written in the current/last load
//   expected_sum, checksum, checksum_err - checksum feature only
module shader_loader
  import gpu_pkg::*;
#(
  parameter int                 ADDR_W     = 20,
  parameter int                 DATA_W     = GPU_DATA_W,
  parameter int                 IMEM_AW    = GPU_IMEM_AW,
  parameter int unsigned        LOAD_WORDS = 288,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  input_addr,
  input  logic [DATA_W-1:0]  data_input,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               core_hold,
  output logic               load_done,
  output logic [IMEM_AW:0]   words_loaded
`ifdef SHADER_LOADER_CHECKSUM_EN
  ,
  input  logic [15:0]        expected_sum,
  output logic [15:0]        checksum,
  output logic               checksum_err
`endif
);

  localparam logic [IMEM_AW:0] FULL_CNT = (IMEM_AW+1)'(LOAD_WORDS);

  loader_state_t    state_q, state_d;
  logic             issue_en;
  logic             restart;
  logic             last_issue;
  logic             finish;
  logic             hold_after_q_d;
  logic [IMEM_AW:0] words_q;
  logic             hold_q;
  logic             done_q;
  logic             seen_q;

  shader_fetch_pipe #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IMEM_AW    (IMEM_AW),
    .LOAD_WORDS (LOAD_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .issue_en   (issue_en),
    .last_issue (last_issue),
    .input_addr (input_addr),
    .data_input (data_input),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  always_comb begin
    state_d  = state_q;
    issue_en = 1'b0;
    restart  = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        issue_en = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (start) begin
          restart = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion is declared once the write counter shows the final word has
  // been retired; load_done and the core_hold release are registered from it.
  assign finish = (state_q == DONE) && !seen_q && !start && (words_q == FULL_CNT);

`ifdef SHADER_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        err_q;

  assign hold_after_q_d = (sum_q != expected_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (restart) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (imem_we) sum_q <= sum_q + 16'(imem_wdata);
      if (finish)  err_q <= hold_after_q_d;
    end
  end

  assign checksum     = sum_q;
  assign checksum_err = err_q;
`else
  assign hold_after_q_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      words_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (restart) begin
        words_q <= '0;
        hold_q  <= 1'b1;
        seen_q  <= 1'b0;
      end else begin
        if (imem_we && (words_q != FULL_CNT)) words_q <= words_q + 1'b1;
        if (finish) begin
          seen_q <= 1'b1;
          hold_q <= hold_after_q_d;
        end
      end
    end
  end

  assign core_hold    = hold_q;
  assign load_done    = done_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_shader_loader.sv
module tb_shader_loader;
  import gpu_pkg::*;

  localparam int L = 288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: LOAD_WORDS=288, BASE_ADDR=0
  logic        rst, start;
  logic [19:0] input_addr;
  logic [15:0] data_input;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        core_hold, load_done;
  logic [10:0] words_loaded;

  // Small instance: LOAD_WORDS=1, BASE_ADDR=20'hFFFFF
  logic        s_rst, s_start;
  logic [19:0] s_addr;
  logic [15:0] s_data;
  logic        s_we;
  logic [9:0]  s_waddr;
  logic [15:0] s_wdata;
  logic        s_hold, s_done;
  logic [10:0] s_words;

`ifdef SHADER_LOADER_CHECKSUM_EN
  logic [15:0] expected_sum, checksum, s_checksum;
  logic        checksum_err, s_checksum_err;
`endif

  shader_loader #(.LOAD_WORDS(288), .BASE_ADDR(20'h00000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_addr(input_addr), .data_input(data_input),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .words_loaded(words_loaded)
`ifdef SHADER_LOADER_CHECKSUM_EN
    , .expected_sum(expected_sum), .checksum(checksum), .checksum_err(checksum_err)
`endif
  );

  shader_loader #(.LOAD_WORDS(1), .BASE_ADDR(20'hFFFFF)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start),
    .input_addr(s_addr), .data_input(s_data),
    .imem_we(s_we), .imem_waddr(s_waddr), .imem_wdata(s_wdata),
    .core_hold(s_hold), .load_done(s_done), .words_loaded(s_words)
`ifdef SHADER_LOADER_CHECKSUM_EN
    , .expected_sum(16'h5A5A), .checksum(s_checksum), .checksum_err(s_checksum_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int total_done = 0;
  logic mem_ones = 1'b0;

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return mem_ones ? 16'h0001 : (a[15:0] ^ 16'hA5A5);
  endfunction

  // External program store, exactly one cycle of read latency.
  always @(posedge clk) data_input <= mem_word(input_addr);
  always @(posedge clk) s_data     <= s_addr[15:0] ^ 16'hA5A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected-write scoreboard
  typedef struct { int idx; logic [9:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];

  task automatic push_load();
    for (int k = 0; k < L; k++) begin
      wr_t w;
      w.idx  = k;
      w.addr = 10'(k);
      w.data = mem_word(20'(k));
      exp_q.push_back(w);
    end
  endtask

  // Checkpoints relative to the first FETCH cycle (c=0); c=-1 is the IDLE cycle.
  typedef struct {
    int          cyc;
    logic [19:0] addr;
    logic        we;
    logic [10:0] words;
    logic        hold;
    logic        done;
  } vec_t;
  vec_t tbl[12];

  task automatic check_reset(input string tag);
    check({tag, " rst addr"},  input_addr, 20'h0);
    check({tag, " rst we"},    imem_we, 1'b0);
    check({tag, " rst waddr"}, imem_waddr, 10'h0);
    check({tag, " rst wdata"}, imem_wdata, 16'h0);
    check({tag, " rst hold"},  core_hold, 1'b1);
    check({tag, " rst done"},  load_done, 1'b0);
    check({tag, " rst words"}, words_loaded, 11'd0);
  endtask

  // Called at the negedge where the trigger (rst or start) was just lowered.
  task automatic run_load(input string tag, input int abort_c, input int start_c,
                          input logic hold_after);
    int we_cnt = 0;
    int done_cnt = 0;
    for (int c = -1; c <= L + 6; c++) begin
      start = (c == start_c);
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].cyc == c) begin
          logic exp_hold;
          exp_hold = (c >= L + 3) ? hold_after : tbl[i].hold;
          check($sformatf("%s c%0d addr", tag, c),  input_addr, tbl[i].addr);
          check($sformatf("%s c%0d we", tag, c),    imem_we, tbl[i].we);
          check($sformatf("%s c%0d words", tag, c), words_loaded, tbl[i].words);
          check($sformatf("%s c%0d hold", tag, c),  core_hold, exp_hold);
          check($sformatf("%s c%0d done", tag, c),  load_done, tbl[i].done);
        end
      end
      if (imem_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          check({tag, " unexpected write"}, 32'(c), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          $display("%s write #%0d: waddr=%0d wdata=%04h (exp %0d/%04h)",
                   tag, e.idx, imem_waddr, imem_wdata, e.addr, e.data);
          check({tag, " waddr"}, imem_waddr, e.addr);
          check({tag, " wdata"}, imem_wdata, e.data);
          check({tag, " write slot"}, 32'(c), 32'(e.idx + 2));
        end
      end
      if (load_done) begin
        done_cnt++;
        total_done++;
        check({tag, " load_done cycle"}, 32'(c), 32'(L + 3));
      end
      if (c == abort_c) return;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " write count"}, we_cnt, L);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " scoreboard empty"}, exp_q.size(), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{-1,   20'd0,   1'b0, 11'd0,   1'b1, 1'b0};
    tbl[1]  = '{0,    20'd0,   1'b0, 11'd0,   1'b1, 1'b0};
    tbl[2]  = '{1,    20'd1,   1'b0, 11'd0,   1'b1, 1'b0};
    tbl[3]  = '{2,    20'd2,   1'b1, 11'd0,   1'b1, 1'b0};
    tbl[4]  = '{3,    20'd3,   1'b1, 11'd1,   1'b1, 1'b0};
    tbl[5]  = '{150,  20'd150, 1'b1, 11'd148, 1'b1, 1'b0};
    tbl[6]  = '{287,  20'd287, 1'b1, 11'd285, 1'b1, 1'b0};
    tbl[7]  = '{288,  20'd287, 1'b1, 11'd286, 1'b1, 1'b0};
    tbl[8]  = '{289,  20'd287, 1'b1, 11'd287, 1'b1, 1'b0};
    tbl[9]  = '{290,  20'd287, 1'b0, 11'd288, 1'b1, 1'b0};
    tbl[10] = '{291,  20'd287, 1'b0, 11'd288, 1'b0, 1'b1};
    tbl[11] = '{292,  20'd287, 1'b0, 11'd288, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; s_rst = 1'b1; s_start = 1'b0;
`ifdef SHADER_LOADER_CHECKSUM_EN
    expected_sum = 16'h0120;
`endif
    repeat (3) @(negedge clk);
    check_reset("init");

    // Automatic load after reset release
    push_load();
    rst = 1'b0;
    run_load("load1", 1000, -100, 1'b0);

    // Restart from DONE, then reset (with coincident start) at write 100
    pulse_start();
    push_load();
    run_load("pre_rst", 102, -100, 1'b0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset("midload");
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    push_load();
    run_load("after_rst", 1000, -100, 1'b0);

    // start during FETCH is ignored
    pulse_start();
    push_load();
    run_load("start_fetch", 1000, 50, 1'b0);
    check("total load_done pulses", total_done, 3);

    // LOAD_WORDS=1 at the top of the address space
    s_rst = 1'b0;
    for (int c = -1; c <= 6; c++) begin
      check($sformatf("small c%0d addr", c), s_addr, 20'hFFFFF);
      check($sformatf("small c%0d we", c),   s_we, (c == 2));
      check($sformatf("small c%0d hold", c), s_hold, (c < 4));
      check($sformatf("small c%0d done", c), s_done, (c == 4));
      if (s_we) begin
        $display("small write: waddr=%0d wdata=%04h", s_waddr, s_wdata);
        check("small waddr", s_waddr, 10'd0);
        check("small wdata", s_wdata, 16'h5A5A);
      end
      @(negedge clk);
    end
    check("small words", s_words, 11'd1);

`ifdef SHADER_LOADER_CHECKSUM_EN
    mem_ones = 1'b1;
    @(negedge clk);
    expected_sum = 16'h0120;
    pulse_start();
    push_load();
    run_load("cks_ok", 1000, -100, 1'b0);
    check("cks_ok checksum", checksum, 16'h0120);
    check("cks_ok err", checksum_err, 1'b0);

    expected_sum = 16'h0121;
    pulse_start();
    push_load();
    run_load("cks_bad", 1000, -100, 1'b1);
    check("cks_bad checksum", checksum, 16'h0120);
    check("cks_bad err", checksum_err, 1'b1);
    check("cks_bad hold", core_hold, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
